// File: rtl/ddr3_wb_bist.sv
// Pipelined Wishbone traffic generator for ddr3_top bring-up: writes an address-derived
// pattern, reads it back in order, and reports error count, first failing address and bus timeout.
module ddr3_wb_bist #(
  parameter int                AWIDTH          = 24,
  parameter int                DWIDTH          = 64,
  parameter int                NUM_WORDS       = 256,
  parameter logic [AWIDTH-1:0] BASE_ADDR       = '0,
  parameter logic [31:0]       SEED            = 32'hA5C3_0F1E,
  parameter int                MAX_OUTSTANDING = 8,
  parameter int                TIMEOUT         = 4096
) (
  input  logic                  i_controller_clk,
  input  logic                  i_rst,
  input  logic                  i_calib_done,
  input  logic                  i_start,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [AWIDTH-1:0]     o_wb_addr,
  output logic [DWIDTH-1:0]     o_wb_data,
  output logic [DWIDTH/8-1:0]   o_wb_sel,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_ack,
  input  logic [DWIDTH-1:0]     i_wb_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [15:0]           o_err_count,
  output logic [AWIDTH-1:0]     o_first_err_addr
);

  localparam int              CW         = AWIDTH + 1;
  localparam logic [CW-1:0]   LP_NUM     = CW'(NUM_WORDS);
  localparam logic [CW-1:0]   LP_LAST    = CW'(NUM_WORDS - 1);
  localparam logic [7:0]      LP_MAXO    = 8'(MAX_OUTSTANDING);
  localparam logic [31:0]     LP_TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WDRAIN, S_READ, S_RDRAIN, S_DONE
  } state_t;

  function automatic logic [DWIDTH-1:0] f_pattern(input logic [AWIDTH-1:0] a);
    return {(DWIDTH/32){32'(a) ^ SEED}};
  endfunction

  state_t            r_state;
  logic [CW-1:0]     r_issue_cnt;
  logic [7:0]        r_outst;
  logic [31:0]       r_idle_cnt;
  logic [AWIDTH-1:0] r_addr;
  logic [AWIDTH-1:0] r_ack_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic              r_we;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;
  logic [15:0]       r_err_count;
  logic [AWIDTH-1:0] r_first_err_addr;

  logic              w_active;
  logic              w_issue_phase;
  logic              w_stb;
  logic              w_accept;
  logic              w_ack;
  logic              w_rd_ack;
  logic              w_mismatch;
  logic              w_abort;
  logic [AWIDTH-1:0] w_next_addr;

  assign w_active      = r_state inside {S_WRITE, S_WDRAIN, S_READ, S_RDRAIN};
  assign w_issue_phase = r_state inside {S_WRITE, S_READ};
  assign w_stb         = w_issue_phase && (r_issue_cnt < LP_NUM) && (r_outst < LP_MAXO);
  assign w_accept      = w_stb && !i_wb_stall;
  // Acks that arrive with nothing outstanding are stray and must not corrupt the counters.
  assign w_ack         = w_active && i_wb_ack && (r_outst != 8'd0);
  assign w_rd_ack      = w_ack && (r_state inside {S_READ, S_RDRAIN});
  assign w_mismatch    = w_rd_ack && (i_wb_data != f_pattern(r_ack_addr));
  assign w_abort       = w_active && (!i_calib_done ||
                         ((r_outst != 8'd0) && !w_ack && (r_idle_cnt == LP_TO_LAST)));
  assign w_next_addr   = r_addr + AWIDTH'(1);

  assign o_wb_cyc         = w_active;
  assign o_wb_stb         = w_stb;
  assign o_wb_we          = r_we;
  assign o_wb_addr        = r_addr;
  assign o_wb_data        = r_wdata;
  assign o_wb_sel         = '1;
  assign o_busy           = w_active;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_timeout        = r_timeout;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

  always_ff @(posedge i_controller_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_issue_cnt      <= '0;
      r_outst          <= '0;
      r_idle_cnt       <= '0;
      r_addr           <= '0;
      r_ack_addr       <= '0;
      r_wdata          <= '0;
      r_we             <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else begin
      if (w_accept) begin
        r_issue_cnt <= r_issue_cnt + CW'(1);
        r_addr      <= w_next_addr;
        r_wdata     <= f_pattern(w_next_addr);
      end

      if (w_accept && !w_ack)      r_outst <= r_outst + 8'd1;
      else if (!w_accept && w_ack) r_outst <= r_outst - 8'd1;

      if (!w_active || w_ack || (r_outst == 8'd0)) r_idle_cnt <= '0;
      else                                         r_idle_cnt <= r_idle_cnt + 32'd1;

      // Read acks complete in order, so a private counter names the word being returned.
      if (w_rd_ack) r_ack_addr <= r_ack_addr + AWIDTH'(1);
      if (w_mismatch) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        if (r_err_count == 16'd0)    r_first_err_addr <= r_ack_addr;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start && i_calib_done) begin
            r_state          <= S_WRITE;
            r_issue_cnt      <= '0;
            r_outst          <= '0;
            r_idle_cnt       <= '0;
            r_addr           <= BASE_ADDR;
            r_ack_addr       <= BASE_ADDR;
            r_wdata          <= f_pattern(BASE_ADDR);
            r_we             <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
          end
        end
        S_WRITE: begin
          if (w_accept && (r_issue_cnt == LP_LAST)) r_state <= S_WDRAIN;
        end
        S_WDRAIN: begin
          if (r_outst == 8'd0) begin
            r_state     <= S_READ;
            r_issue_cnt <= '0;
            r_addr      <= BASE_ADDR;
            r_ack_addr  <= BASE_ADDR;
            r_wdata     <= f_pattern(BASE_ADDR);
            r_we        <= 1'b0;
          end
        end
        S_READ: begin
          if (w_accept && (r_issue_cnt == LP_LAST)) r_state <= S_RDRAIN;
        end
        S_RDRAIN: begin
          if (r_outst == 8'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == 16'd0) && !r_timeout;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A lost calibration is treated like a hung bus: abandon the pass and report it failed.
      if (w_abort) begin
        r_state   <= S_DONE;
        r_timeout <= 1'b1;
        r_done    <= 1'b1;
        r_pass    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_wb_bist.sv
// Directed bench for ddr3_wb_bist: a behavioural Wishbone memory slave with configurable
// latency, stalls, corruption and ack withholding, plus hand-computed expectations.
module tb_ddr3_wb_bist;

  localparam int          NW    = 16;
  localparam int          MAXO  = 4;
  localparam logic [23:0] BASE  = 24'h000100;
  localparam logic [31:0] SEEDV = 32'hA5C3_0F1E;

  logic        clk;
  logic        i_rst;
  logic        i_calib_done;
  logic        i_start;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [23:0] o_wb_addr;
  logic [63:0] o_wb_data;
  logic [7:0]  o_wb_sel;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic [63:0] i_wb_data;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic        o_timeout;
  logic [15:0] o_err_count;
  logic [23:0] o_first_err_addr;

  int checks;
  int failures;

  ddr3_wb_bist #(
    .AWIDTH(24), .DWIDTH(64), .NUM_WORDS(NW), .BASE_ADDR(BASE), .SEED(SEEDV),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT(64)
  ) dut (
    .i_controller_clk(clk), .i_rst(i_rst), .i_calib_done(i_calib_done), .i_start(i_start),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
    .i_wb_data(i_wb_data), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_timeout(o_timeout), .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [23:0] addr; logic we; int due; } req_t;
  typedef struct { logic [23:0] addr; logic [63:0] data; } log_t;

  req_t        pend[$];
  log_t        wrLog[$];
  log_t        rdLog[$];
  logic [63:0] mem [logic [23:0]];
  int          cycleNo;
  int          latency;
  bit          stallMode;
  bit          withhold;
  bit          corruptEn;
  int          maxOut;
  int          stbWhileFull;
  int          stallErr;

  function automatic logic [63:0] pat(input logic [23:0] a);
    logic [31:0] w;
    w = {8'h00, a} ^ SEEDV;
    return {w, w};
  endfunction

  function automatic logic [63:0] readMem(input logic [23:0] a);
    logic [63:0] d;
    d = mem.exists(a) ? mem[a] : 64'h0;
    if (corruptEn && a == BASE + 24'd5) d = d ^ 64'h1;
    if (corruptEn && a == BASE + 24'd9) d = d ^ 64'h80;
    return d;
  endfunction

  function automatic int countSeqErrors();
    int bad;
    bad = 0;
    for (int i = 0; i < NW; i++) begin
      if (i < wrLog.size() && (wrLog[i].addr != BASE + 24'(i) || wrLog[i].data != pat(BASE + 24'(i))))
        bad++;
      if (i < rdLog.size() && rdLog[i].addr != BASE + 24'(i)) bad++;
    end
    return bad;
  endfunction

  // Slave: requests seen at the negedge are the ones the DUT accepts at the following posedge.
  initial begin : slave
    logic        sAcc, sAckd, sRst, sWe, havePrev;
    logic [23:0] sAddr, pAddr;
    logic [63:0] sData, pData;
    logic        pWe;
    i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_data = 64'h0;
    cycleNo = 0; havePrev = 1'b0;
    pAddr = '0; pData = '0; pWe = 1'b0;
    forever begin
      @(negedge clk);
      sAcc  = o_wb_cyc && o_wb_stb && !i_wb_stall;
      sAddr = o_wb_addr; sData = o_wb_data; sWe = o_wb_we;
      sAckd = i_wb_ack;  sRst  = i_rst;
      if (o_wb_stb && pend.size() >= MAXO) stbWhileFull++;
      if (havePrev && o_wb_stb && !sRst && (o_wb_addr != pAddr || o_wb_data != pData || o_wb_we != pWe))
        stallErr++;
      havePrev = o_wb_stb && i_wb_stall;
      pAddr = o_wb_addr; pData = o_wb_data; pWe = o_wb_we;
      @(posedge clk);
      #1;
      cycleNo++;
      if (sRst) begin
        pend.delete();
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; havePrev = 1'b0;
      end else begin
        if (sAckd && pend.size() > 0) void'(pend.pop_front());
        if (sAcc) begin
          if (sWe) begin
            mem[sAddr] = sData;
            wrLog.push_back('{sAddr, sData});
          end else begin
            rdLog.push_back('{sAddr, 64'h0});
          end
          pend.push_back('{sAddr, sWe, cycleNo + latency});
        end
        if (pend.size() > maxOut) maxOut = pend.size();
        i_wb_ack = 1'b0;
        if (!withhold && pend.size() > 0 && pend[0].due <= cycleNo + 1) begin
          i_wb_ack  = 1'b1;
          i_wb_data = pend[0].we ? 64'h0 : readMem(pend[0].addr);
        end
        i_wb_stall = stallMode ? !i_wb_stall : 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic clearScoreboard();
    wrLog.delete(); rdLog.delete();
    maxOut = 0; stbWhileFull = 0; stallErr = 0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int n);
    n = 0;
    while (!o_done && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_done_in_time"}, o_done, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctrl_bits"},
                {o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_pass, o_timeout}, 0);
    checkOutput({tag, "_addr"}, o_wb_addr, 0);
    checkOutput({tag, "_data"}, o_wb_data, 0);
    checkOutput({tag, "_sel"}, o_wb_sel, 8'hFF);
    checkOutput({tag, "_err_count"}, o_err_count, 0);
    checkOutput({tag, "_first_err"}, o_first_err_addr, 0);
  endtask

  task automatic checkCleanPass(input string tag);
    checkOutput({tag, "_pass"}, o_pass, 1);
    checkOutput({tag, "_err_count"}, o_err_count, 0);
    checkOutput({tag, "_timeout"}, o_timeout, 0);
    checkOutput({tag, "_wr_count"}, wrLog.size(), NW);
    checkOutput({tag, "_rd_count"}, rdLog.size(), NW);
    checkOutput({tag, "_order"}, countSeqErrors(), 0);
  endtask

  initial begin : stimulus
    int n;
    checks = 0; failures = 0;
    latency = 3; stallMode = 0; withhold = 0; corruptEn = 0;
    i_rst = 1'b1; i_calib_done = 1'b1; i_start = 1'b0;
    clearScoreboard();
    tick(2);
    checkResetState("reset");
    i_rst = 1'b0;
    tick(1);

    // Ideal slave, three-cycle ack latency.
    applyStimulus();
    checkOutput("t1_busy_after_start", o_busy, 1);
    checkOutput("t1_first_req", {o_wb_stb, o_wb_we, o_wb_cyc}, 3'b111);
    checkOutput("t1_first_addr", o_wb_addr, BASE);
    checkOutput("t1_first_data", o_wb_data, pat(BASE));
    waitDone("t1", 2000, n);
    checkCleanPass("t1");
    checkOutput("t1_idle_bus", {o_wb_cyc, o_busy}, 0);
    checkOutput("t1_first_err", o_first_err_addr, 0);
    checkOutput("t1_max_outst", maxOut <= MAXO, 1);

    // Alternating stall.
    clearScoreboard();
    stallMode = 1;
    applyStimulus();
    waitDone("t2", 2000, n);
    stallMode = 0;
    checkCleanPass("t2");
    checkOutput("t2_stable_during_stall", stallErr, 0);

    // Corrupted read data at two addresses.
    clearScoreboard();
    corruptEn = 1;
    applyStimulus();
    waitDone("t3", 2000, n);
    corruptEn = 0;
    checkOutput("t3_err_count", o_err_count, 2);
    checkOutput("t3_first_err", o_first_err_addr, BASE + 24'd5);
    checkOutput("t3_pass", o_pass, 0);
    checkOutput("t3_timeout", o_timeout, 0);

    // Long latency fills the outstanding window; a second start mid-pass is ignored.
    clearScoreboard();
    latency = 10;
    applyStimulus();
    tick(20);
    applyStimulus();
    waitDone("t5", 3000, n);
    latency = 3;
    checkCleanPass("t5");
    checkOutput("t5_max_outst", maxOut, MAXO);
    checkOutput("t5_stb_while_full", stbWhileFull, 0);

    // Calibration lost mid-pass, then a start without calibration.
    clearScoreboard();
    applyStimulus();
    tick(10);
    i_calib_done = 1'b0;
    tick(2);
    checkOutput("calib_abort_flags", {o_done, o_timeout, o_pass, o_wb_cyc}, 4'b1100);
    applyStimulus();
    checkOutput("calib_low_start_ignored", {o_busy, o_done}, 2'b01);
    i_calib_done = 1'b1;
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    tick(1);

    // Acks withheld: abort after TIMEOUT idle cycles.
    clearScoreboard();
    withhold = 1;
    applyStimulus();
    waitDone("t4", 500, n);
    checkOutput("t4_timeout", o_timeout, 1);
    checkOutput("t4_cyc_dropped", {o_wb_cyc, o_wb_stb, o_busy}, 0);
    checkOutput("t4_pass", o_pass, 0);
    checkOutput("t4_latency_about_64", (n >= 60 && n <= 70), 1);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    withhold = 0;
    tick(1);

    // Reset at word 7 of the write phase, then a clean pass.
    clearScoreboard();
    applyStimulus();
    n = 0;
    while (wrLog.size() < 7 && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput("t6_reached_word7", wrLog.size() >= 7, 1);
    i_rst = 1'b1;
    tick(1);
    checkResetState("t6_midpass_reset");
    i_rst = 1'b0;
    tick(2);
    clearScoreboard();
    applyStimulus();
    waitDone("t6", 2000, n);
    checkCleanPass("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
